ram_port_arbiter: RTL and testbench

//  Shares the single data-RAM port (address, write data, write enable, read data) between Num_Req

---
 rtl/ram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one synchronous-read data-RAM port between Num_Req requesters
// (index 0 is the core move-unit, the rest are DMA/IO engines). Requesters
// are served round-robin with a req/gnt handshake. A grant lasts until the
// owner drops req, signals last, or reaches Max_Burst accesses. Every release
// is followed by one idle turnaround cycle, and arbitration happens in that
// cycle. Read data returns one cycle after the access and is tagged with an
// rvalid bit for the requester that issued the read.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous reset, active low
//   req        per-requester access request
//   we         per-requester write (1) / read (0)
//   last       this cycle's access is the final one of the burst
//   addr       packed addresses, requester i at [i*Addr_Size +: Addr_Size]
//   wdata      packed write data, packed the same way as addr
//   gnt        one-hot grant (registered)
//   rvalid     one-hot read-data-valid for the requester that issued the read
//   rdata      read data, passed straight through from ram_rdata
//   ram_addr   RAM address, muxed from the current owner
//   ram_wdata  RAM write data, muxed from the current owner
//   ram_we     RAM write enable, high only on an owner write access
//   ram_rdata  RAM read data, valid one cycle after the read address
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int Num_Req   = 2,
    parameter int Data_Size = 16,
    parameter int Addr_Size = 6,
    parameter int Max_Burst = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [Num_Req-1:0]             req,
    input  logic [Num_Req-1:0]             we,
    input  logic [Num_Req-1:0]             last,
    input  logic [Num_Req*Addr_Size-1:0]   addr,
    input  logic [Num_Req*Data_Size-1:0]   wdata,
    output logic [Num_Req-1:0]             gnt,
    output logic [Num_Req-1:0]             rvalid,
    output logic [Data_Size-1:0]           rdata,
    output logic [Addr_Size-1:0]           ram_addr,
    output logic [Data_Size-1:0]           ram_wdata,
    output logic                           ram_we,
    input  logic [Data_Size-1:0]           ram_rdata
);

    localparam int Ptr_W = (Num_Req > 1) ? $clog2(Num_Req) : 1;
    // Wide enough to hold Max_Burst-1, with at least one bit.
    localparam int Cnt_W = $clog2(Max_Burst + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [Ptr_W-1:0]   rr_ptr;
    logic [Ptr_W-1:0]   owner;
    logic [Cnt_W-1:0]   burst_cnt;

    logic [Ptr_W-1:0]   winner;
    logic               own_req;
    logic               own_we;
    logic               own_last;
    logic               access;
    logic               burst_full;
    logic [Num_Req-1:0] owner_onehot;
    logic [Num_Req-1:0] winner_onehot;

    // -------------------------------------------------------------------------
    // Round-robin pick: first set request bit starting at ptr, wrapping at
    // Num_Req (which need not be a power of two).
    // -------------------------------------------------------------------------
    function automatic logic [Ptr_W-1:0] rr_pick(
        input logic [Num_Req-1:0] r,
        input logic [Ptr_W-1:0]   ptr
    );
        logic [Ptr_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < Num_Req; i++) begin
            idx = int'(ptr) + i;
            if (idx >= Num_Req) begin
                idx = idx - Num_Req;
            end
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = Ptr_W'(idx);
            end
        end
        return pick;
    endfunction

    // Pointer to the requester after w, wrapping at Num_Req.
    function automatic logic [Ptr_W-1:0] next_ptr(input logic [Ptr_W-1:0] w);
        if (w == Ptr_W'(Num_Req - 1)) begin
            return '0;
        end
        return w + 1'b1;
    endfunction

    assign winner = rr_pick(req, rr_ptr);

    assign owner_onehot  = {{(Num_Req-1){1'b0}}, 1'b1} << owner;
    assign winner_onehot = {{(Num_Req-1){1'b0}}, 1'b1} << winner;

    // -------------------------------------------------------------------------
    // Owner-side datapath. Inputs of non-owners never reach the RAM port.
    // -------------------------------------------------------------------------
    assign own_req  = req[owner];
    assign own_we   = we[owner];
    assign own_last = last[owner];

    // gnt is cleared asynchronously by reset, so access and ram_we fall with
    // rst_n and an in-flight write is never committed.
    assign access     = gnt[owner] & own_req;
    assign burst_full = (burst_cnt == Cnt_W'(Max_Burst - 1));

    assign ram_addr  = addr[int'(owner)*Addr_Size +: Addr_Size];
    assign ram_wdata = wdata[int'(owner)*Data_Size +: Data_Size];
    assign ram_we    = access & own_we;

    // The RAM's registered read data lines up with the registered rvalid tag.
    assign rdata = ram_rdata;

    // -------------------------------------------------------------------------
    // Arbitration FSM with registered gnt / rvalid.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            rvalid    <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            owner     <= '0;
        end else begin
            // A read in this cycle is answered next cycle, tagged to the
            // requester that issued it, whatever happens to the grant.
            if (access && !own_we) begin
                rvalid <= owner_onehot;
            end else begin
                rvalid <= '0;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= winner;
                        gnt       <= winner_onehot;
                        burst_cnt <= '0;
                        // The pointer only moves on a grant, never on release.
                        rr_ptr    <= next_ptr(winner);
                        state     <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end

                GRANT: begin
                    if (access) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    // Release when the owner stops asking, ends its burst, or
                    // uses up its burst allowance; one idle cycle follows.
                    if (!access || own_last || burst_full) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end

                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter with two requesters. A table of
// per-cycle records (inputs plus expected outputs) covers single writes,
// round-robin fairness, the burst cap, reads and early release; a hand-written
// sequence covers reset in the middle of a burst. A small synchronous-read RAM
// model sits on the RAM port.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int Num_Req   = 2;
    localparam int Data_Size = 16;
    localparam int Addr_Size = 6;
    localparam int Max_Burst = 4;

    logic                         clk;
    logic                         rst_n;
    logic [Num_Req-1:0]           req;
    logic [Num_Req-1:0]           we;
    logic [Num_Req-1:0]           last;
    logic [Num_Req*Addr_Size-1:0] addr;
    logic [Num_Req*Data_Size-1:0] wdata;
    logic [Num_Req-1:0]           gnt;
    logic [Num_Req-1:0]           rvalid;
    logic [Data_Size-1:0]         rdata;
    logic [Addr_Size-1:0]         ram_addr;
    logic [Data_Size-1:0]         ram_wdata;
    logic                         ram_we;
    logic [Data_Size-1:0]         ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    ram_port_arbiter #(
        .Num_Req  (Num_Req),
        .Data_Size(Data_Size),
        .Addr_Size(Addr_Size),
        .Max_Burst(Max_Burst)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .last     (last),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten words read back as A000|addr, except 0x2A = BEEF.
    logic [Data_Size-1:0] mem     [64];
    bit                   written [64];

    function automatic logic [Data_Size-1:0] peek(input logic [Addr_Size-1:0] a);
        if (written[a]) return mem[a];
        if (a == 6'h2A) return 16'hBEEF;
        return 16'hA000 | {10'd0, a};
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= peek(ram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [1:0]  last;
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [15:0] e_wdata;
        logic [1:0]  e_rvalid;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] rq, input logic [1:0] w, input logic [1:0] l,
        input logic [5:0] a0, input logic [5:0] a1, input logic [15:0] d0, input logic [15:0] d1,
        input logic [1:0] eg, input logic ewe, input logic [5:0] ea, input logic [15:0] ewd,
        input logic [1:0] erv, input logic [15:0] erd);
        vec_t v;
        v.rst = rst;  v.req = rq;  v.we = w;  v.last = l;
        v.a0 = a0;    v.a1 = a1;   v.d0 = d0; v.d1 = d1;
        v.e_gnt = eg; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
        v.e_rvalid = erv; v.e_rdata = erd;
        return v;
    endfunction

    task automatic idle_inputs();
        req   = '0;
        we    = '0;
        last  = '0;
        addr  = '0;
        wdata = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ram_rdata = '0;
        idle_inputs();

        // ---- T1: single write by requester 0, then rr_ptr moved to 1 ----
        vq.push_back(mk(1'b1, 2'b01, 2'b01, 2'b01, 6'h05, 6'h00, 16'h1234, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b01, 6'h05, 6'h00, 16'h1234, 16'h0000, 2'b01, 1'b1, 6'h05, 16'h1234, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b00, 2'b11, 6'h03, 6'h07, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b00, 2'b11, 6'h03, 6'h07, 16'h0000, 16'h0000, 2'b10, 1'b0, 6'h07, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b10, 16'hA007));
        // ---- T2: both requesting, single-access bursts: 0,1,0,1 with gaps ----
        vq.push_back(mk(1'b1, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b01, 1'b1, 6'd10, 16'h0101, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b10, 1'b1, 6'd20, 16'h0202, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b01, 1'b1, 6'd10, 16'h0101, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 6'd10, 6'd20, 16'h0101, 16'h0202, 2'b10, 1'b1, 6'd20, 16'h0202, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        // ---- T3: burst cap: 4 for 0, gap, 1 for 1, gap, remaining 2 for 0 ----
        vq.push_back(mk(1'b1, 2'b11, 2'b11, 2'b10, 6'h20, 6'h30, 16'h3000, 16'h3333, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 6'h20, 6'h30, 16'h3000, 16'h3333, 2'b01, 1'b1, 6'h20, 16'h3000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 6'h21, 6'h30, 16'h3001, 16'h3333, 2'b01, 1'b1, 6'h21, 16'h3001, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 6'h22, 6'h30, 16'h3002, 16'h3333, 2'b01, 1'b1, 6'h22, 16'h3002, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 6'h23, 6'h30, 16'h3003, 16'h3333, 2'b01, 1'b1, 6'h23, 16'h3003, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 6'h24, 6'h30, 16'h3004, 16'h3333, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 6'h24, 6'h30, 16'h3004, 16'h3333, 2'b10, 1'b1, 6'h30, 16'h3333, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b11, 2'b10, 6'h24, 6'h30, 16'h3004, 16'h3333, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b11, 2'b10, 6'h24, 6'h30, 16'h3004, 16'h3333, 2'b01, 1'b1, 6'h24, 16'h3004, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b11, 2'b11, 6'h25, 6'h30, 16'h3005, 16'h3333, 2'b01, 1'b1, 6'h25, 16'h3005, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        // ---- T5: owner drops req mid-grant; next grant gets a fresh burst ----
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h11, 6'h00, 16'h5001, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h11, 6'h00, 16'h5001, 16'h0000, 2'b01, 1'b1, 6'h11, 16'h5001, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h12, 6'h00, 16'h5002, 16'h0000, 2'b01, 1'b1, 6'h12, 16'h5002, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b01, 2'b00, 6'h12, 6'h00, 16'h5002, 16'h0000, 2'b01, 1'b0, 6'h12, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h13, 6'h00, 16'h5003, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h13, 6'h00, 16'h5003, 16'h0000, 2'b01, 1'b1, 6'h13, 16'h5003, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h14, 6'h00, 16'h5004, 16'h0000, 2'b01, 1'b1, 6'h14, 16'h5004, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h15, 6'h00, 16'h5005, 16'h0000, 2'b01, 1'b1, 6'h15, 16'h5005, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 6'h16, 6'h00, 16'h5006, 16'h0000, 2'b01, 1'b1, 6'h16, 16'h5006, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        // ---- T4: reads; rvalid is tagged and lasts exactly one cycle ----
        vq.push_back(mk(1'b1, 2'b10, 2'b00, 2'b10, 6'h00, 6'h2A, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b10, 2'b00, 2'b10, 6'h00, 6'h2A, 16'h0000, 16'h0000, 2'b10, 1'b0, 6'h2A, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b10, 16'hBEEF));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b00, 2'b11, 6'h01, 6'h2A, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b00, 2'b11, 6'h01, 6'h2A, 16'h0000, 16'h0000, 2'b01, 1'b0, 6'h01, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b11, 2'b00, 2'b11, 6'h01, 6'h2A, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b01, 16'hA001));
        vq.push_back(mk(1'b0, 2'b11, 2'b00, 2'b11, 6'h01, 6'h2A, 16'h0000, 16'h0000, 2'b10, 1'b0, 6'h2A, 16'h0000, 2'b00, 16'h0000));
        vq.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 2'b00, 1'b0, 6'h00, 16'h0000, 2'b10, 16'hBEEF));

        // Each record is one clock cycle: drive, settle, compare, advance.
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) begin
                do_reset();
            end
            req   = vq[i].req;
            we    = vq[i].we;
            last  = vq[i].last;
            addr  = {vq[i].a1, vq[i].a0};
            wdata = {vq[i].d1, vq[i].d0};
            #1;
            check($sformatf("v%0d gnt", i),    32'(gnt),    32'(vq[i].e_gnt));
            check($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vq[i].e_we));
            check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vq[i].e_rvalid));
            if (vq[i].e_gnt != 2'b00) begin
                check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vq[i].e_addr));
            end
            if (vq[i].e_we) begin
                check($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(vq[i].e_wdata));
            end
            if (vq[i].e_rvalid != 2'b00) begin
                check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vq[i].e_rdata));
            end
            @(posedge clk);
            #1;
        end

        check("t1 mem[5] written", 32'(peek(6'h05)), 32'h1234);

        // ---- T6: reset in the middle of a read-then-write burst ----
        do_reset();
        req  = 2'b01;
        we   = 2'b00;
        last = 2'b00;
        addr = {6'h00, 6'h2A};
        #1;
        check("t6 idle gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        check("t6 grant 0", 32'(gnt), 32'h1);
        @(posedge clk);
        #1;
        we    = 2'b01;
        addr  = {6'h00, 6'h3F};
        wdata = {16'h0000, 16'hDEAD};
        #1;
        check("t6 write pending", 32'(ram_we), 32'h1);
        check("t6 rvalid before rst", 32'(rvalid), 32'h1);
        check("t6 rdata before rst", 32'(rdata), 32'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async gnt", 32'(gnt), 32'h0);
        check("t6 async ram_we", 32'(ram_we), 32'h0);
        check("t6 async rvalid", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        check("t6 write dropped", 32'(peek(6'h3F)), 32'hA03F);
        rst_n = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        last  = 2'b11;
        addr  = {6'h02, 6'h01};
        #1;
        check("t6 post-rst idle", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        check("t6 post-rst grant 0", 32'(gnt), 32'h1);
        idle_inputs();
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
